// File: rtl/key_press_classifier_if.sv
// key_press_classifier_if: key inputs and classified-event FIFO handshake
interface key_press_classifier_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic          key_pulse;
  logic          key_level;
  logic          ev_ready;
  logic          clr_ovf;
  logic          ev_valid;
  logic [1:0]    ev_code;
  logic [CW-1:0] ev_count;
  logic          overflow;
  logic          busy;
  modport master (
    output key_pulse, key_level, ev_ready, clr_ovf,
    input  ev_valid, ev_code, ev_count, overflow, busy
  );
  modport slave (
    input  key_pulse, key_level, ev_ready, clr_ovf,
    output ev_valid, ev_code, ev_count, overflow, busy
  );
endinterface

// File: rtl/key_press_classifier.sv
// key_press_classifier: classifies debounced key gestures as SHORT/DOUBLE/LONG and queues them
module key_press_classifier #(
  parameter int TICK_DIV   = 100000,
  parameter int LONG_MS    = 800,
  parameter int DOUBLE_MS  = 300,
  parameter int FIFO_DEPTH = 4
) (
  input logic in_clk,
  input logic reset,
  key_press_classifier_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int MW = $clog2((LONG_MS > DOUBLE_MS ? LONG_MS : DOUBLE_MS) + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, PRESSED1, WAIT2, RELEASE_WAIT} state_t;
  state_t        state;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms;
  logic          tick, long_hit, dbl_hit;
  logic          push, busy_q, ovf;
  logic [1:0]    push_code;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          pop, full, wr, drop;
  // tick and threshold detection from the free-running prescaler and ms counter
  always_comb begin
    tick     = pre == PW'(TICK_DIV - 1);
    long_hit = tick && ms == MW'(LONG_MS - 1);
    dbl_hit  = tick && ms == MW'(DOUBLE_MS - 1);
  end
  // gesture FSM with timer; timer restarts on entry to PRESSED1/WAIT2, push is registered
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state     <= IDLE;
      pre       <= '0;
      ms        <= '0;
      push      <= 1'b0;
      push_code <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      ms   <= tick ? ms + 1'b1 : ms;
      push <= 1'b0;
      case (state)
        IDLE: if (bus.key_pulse) begin
          state  <= PRESSED1;
          pre    <= '0;
          ms     <= '0;
          busy_q <= 1'b1;
        end
        PRESSED1: if (!bus.key_level) begin
          state <= WAIT2;
          pre   <= '0;
          ms    <= '0;
        end else if (long_hit) begin
          state     <= RELEASE_WAIT;
          push      <= 1'b1;
          push_code <= 2'b11;
        end
        WAIT2: if (bus.key_pulse) begin
          state     <= RELEASE_WAIT;
          push      <= 1'b1;
          push_code <= 2'b10;
        end else if (dbl_hit) begin
          state     <= IDLE;
          push      <= 1'b1;
          push_code <= 2'b01;
          busy_q    <= 1'b0;
        end
        RELEASE_WAIT: if (!bus.key_level) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // FIFO control: a pop frees the slot for a same-edge push when full
  always_comb begin
    pop  = cnt != '0 && bus.ev_ready;
    full = cnt == CW'(FIFO_DEPTH);
    wr   = push && (!full || pop);
    drop = push && full && !pop;
  end
  // event FIFO storage, pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge in_clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= push_code;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(pop);
      ovf <= drop || (ovf && !bus.clr_ovf);
    end
  end
  assign bus.ev_valid = cnt != '0;
  assign bus.ev_code  = cnt != '0 ? mem[rp] : 2'b00;
  assign bus.ev_count = cnt;
  assign bus.overflow = ovf;
  assign bus.busy     = busy_q;
endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Sits directly downstream of the keyboard debounce stage and consumes its outputs: the single-cycle press pulse and the debounced key level.
- Classifies each press gesture as SHORT, DOUBLE or LONG using millisecond timing derived from in_clk.
- Queues classified events in a small FIFO with a valid/ready output handshake for the consuming logic.

Parameters:
- TICK_DIV, 100000, in_clk cycles per timing tick (1 ms at 100 MHz)
- LONG_MS, 800, ticks a first press must be held to classify as LONG
- DOUBLE_MS, 300, ticks after a release in which a second press makes a DOUBLE
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2

Ports:
- in_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- key_pulse  in  1  one-cycle press event from debounce stage
- key_level  in  1  debounced key level, 1 = held
- ev_ready  in  1  consumer accepts head event
- clr_ovf  in  1  clears overflow flag
- ev_valid  out  1  FIFO non-empty
- ev_code  out  2  head event: 01 SHORT, 10 DOUBLE, 11 LONG; 00 when empty
- ev_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (in_clk edge with reset=1):
  - FSM to IDLE; prescaler and tick counter to 0; FIFO emptied.
  - Outputs: ev_valid=0, ev_code=00, ev_count=0, overflow=0, busy=0.
  - Any in-flight gesture is discarded. A key still held after reset is ignored until the next key_pulse.
- Timing:
  - Prescaler counts 0..TICK_DIV-1 and issues a one-cycle tick when it equals TICK_DIV-1.
  - On each tick, ms_cnt increments.
  - Prescaler and ms_cnt are both zeroed on the edge that enters PRESSED1 or WAIT2.
  - A threshold N fires on the edge where tick=1 and ms_cnt=N-1. That edge is exactly N×TICK_DIV cycles after the entering edge.
- FSM states: IDLE, PRESSED1, WAIT2, RELEASE_WAIT.
  - IDLE: key_pulse → PRESSED1.
  - PRESSED1:
    - key_level=0 → WAIT2.
    - Otherwise, LONG_MS threshold → push LONG, go to RELEASE_WAIT.
    - key_level=0 on the threshold edge → WAIT2; no LONG is pushed.
  - WAIT2:
    - key_pulse → push DOUBLE, go to RELEASE_WAIT.
    - Otherwise, DOUBLE_MS threshold → push SHORT, go to IDLE.
    - key_pulse on the threshold edge → DOUBLE wins.
  - RELEASE_WAIT: key_level=0 → IDLE.
  - key_pulse is ignored in PRESSED1 and RELEASE_WAIT.
- busy = (state != IDLE), registered.
- FIFO:
  - Push comes from the FSM. Pop occurs when ev_valid & ev_ready.
  - ev_code and ev_valid reflect the head entry directly; no extra latency.
  - A pushed event is visible on the edge after the push edge.
  - Push while full with no pop: event dropped, overflow set to 1.
  - Push while full with a pop on the same edge: the push is accepted, ev_count stays FIFO_DEPTH, no overflow.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH. Ordering is strictly first in, first out.
- Overflow flag:
  - clr_ovf clears overflow.
  - If clr_ovf and a drop occur on the same edge, overflow is set (set wins).

Test Plan (TICK_DIV=4, LONG_MS=10, DOUBLE_MS=5, FIFO_DEPTH=4):
- Short press: key_pulse at edge T, level high 8 cycles then low at T+8, no further pulse → SHORT pushed at edge T+8+20; ev_valid=1, ev_code=01, ev_count=1. ev_ready=1 for one cycle → ev_valid=0.
- Long press: pulse at T, level held 60 cycles → LONG pushed at edge T+40, ev_code=11. Release produces no further event; busy=0 after release.
- Double press: pulse at T, release at T+8, second pulse at T+18 → DOUBLE (10) visible after T+18. No SHORT is ever pushed; busy falls when the level drops.
- Tie case: second pulse lands exactly on the DOUBLE_MS threshold edge (T+8+20) → DOUBLE only, ev_count=1.
- Overflow: ev_ready=0, five SHORT gestures → ev_count=4, overflow=1, head=01.
  - Pop all four → ev_count 3,2,1,0, ev_valid=0.
  - clr_ovf → overflow=0.
  - Full push with a simultaneous pop → no overflow, ev_count stays 4.
- Reset mid-gesture: reset pulsed at T+20 of a held press with 2 queued events → ev_count=0, busy=0. Key held a further 50 cycles with no new pulse → no event.
